seg7_scan_driver: RTL

- Parametrised, time-multiplexed multi-digit 7-segment driver; successor to the single-digit BCD decoder.
- Latches a packed nibble vector and scans one digit per slot.
- Decodes each nibble in BCD or hex mode, with leading-zero blanking, anti-ghost blanking and configurable segment/digit polarity.
- Sits between the datapath, which supplies values, and the board display pins.

---
 rtl/seg7_scan_driver.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed multi-digit 7-segment driver. A packed nibble vector is
//   captured on 'load' into a pending register. It is copied into the
//   displayed shadow register only at the end of a full scan, so a frame never
//   shows a mix of old and new digits. One digit is lit per slot of SCAN_DIV
//   cycles. The first BLANK_CYC cycles of every slot are dark to stop ghosting.
//
//   Optional feature: define SEG7_DP_EN to add per-digit decimal points.
//
//   Ports:
//     clk        in   system clock
//     rst_n      in   synchronous reset, active-low
//     value      in   4*DIGITS packed nibbles, nibble i -> digit i
//     load       in   one-cycle capture strobe for value (and dp)
//     hex_mode   in   1 = hex decode, 0 = BCD decode (10..15 dark)
//     blank_lz   in   1 = blank leading zeros (digit 0 never blanked)
//     seg_inv    in   1 = runtime inversion of segment polarity
//     dp         in   DIGITS decimal points (SEG7_DP_EN only)
//     seg        out  segments, bit6..bit0 = a..g
//     seg_dp     out  decimal point of active digit (SEG7_DP_EN only)
//     dig        out  DIGITS digit enables, one-hot when active
//     frame_done out  one-cycle pulse after each full scan
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYC      = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  input  logic                  seg_inv,
`ifdef SEG7_DP_EN
  input  logic [DIGITS-1:0]     dp,
  output logic                  seg_dp,
`endif
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     P_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]     P_BLANK  = PW'(BLANK_CYC);
  localparam logic [IW-1:0]     I_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] DIG_MASK = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PW-1:0]       r_presc;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_pending;
  logic [4*DIGITS-1:0] r_shadow;
  logic                r_pend_valid;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_dig;
  logic                r_frame_done;

  logic                w_tc;
  logic                w_wrap;
  logic                w_on;
  logic                w_seen;
  logic [DIGITS-1:0]   w_lz;
  logic [DIGITS-1:0]   w_onehot;
  logic [3:0]          w_nib;
  logic                w_blank;
  logic [6:0]          w_pat;
  logic [6:0]          w_pol;

  function automatic logic [6:0] f_decode(input logic [3:0] n, input logic hex);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'b1111110;
      4'h1: p = 7'b0110000;
      4'h2: p = 7'b1101101;
      4'h3: p = 7'b1111001;
      4'h4: p = 7'b0110011;
      4'h5: p = 7'b1011011;
      4'h6: p = 7'b1011111;
      4'h7: p = 7'b1110000;
      4'h8: p = 7'b1111111;
      4'h9: p = 7'b1111011;
      4'hA: p = hex ? 7'b1110111 : 7'b0000000;
      4'hB: p = hex ? 7'b0011111 : 7'b0000000;
      4'hC: p = hex ? 7'b1001110 : 7'b0000000;
      4'hD: p = hex ? 7'b0111101 : 7'b0000000;
      4'hE: p = hex ? 7'b1001111 : 7'b0000000;
      default: p = hex ? 7'b1000111 : 7'b0000000;
    endcase
    return p;
  endfunction

  assign w_tc   = (r_presc == P_LAST);
  assign w_wrap = w_tc && (r_idx == I_LAST);
  assign w_on   = (r_presc >= P_BLANK);
  // Combined polarity: board wiring xor runtime flip.
  assign w_pol  = SEG_MASK ^ {7{seg_inv}};

  // Leading-zero map: walk from the top digit down; a digit is blank while
  // no nonzero nibble has been seen above or at it. Digit 0 is never blank.
  always_comb begin
    w_seen = 1'b0;
    w_lz   = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (r_shadow[i*4 +: 4] != 4'h0) w_seen = 1'b1;
      w_lz[i] = !w_seen;
    end
  end

  always_comb begin
    w_nib    = 4'h0;
    w_blank  = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == r_idx) begin
        w_nib       = r_shadow[i*4 +: 4];
        w_blank     = blank_lz && w_lz[i];
        w_onehot[i] = 1'b1;
      end
    end
    w_pat = w_blank ? 7'b0000000 : f_decode(w_nib, hex_mode);
  end

`ifdef SEG7_DP_EN
  logic [DIGITS-1:0] r_pend_dp;
  logic [DIGITS-1:0] r_shadow_dp;
  logic              r_seg_dp;
  logic              w_dp_bit;

  // Leading-zero blanking deliberately does not touch the decimal point.
  assign w_dp_bit = |(r_shadow_dp & w_onehot);
  assign seg_dp   = r_seg_dp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_dp   <= '0;
      r_shadow_dp <= '0;
      r_seg_dp    <= SEG_MASK[0];
    end else begin
      if (load) r_pend_dp <= dp;
      if (w_wrap) r_shadow_dp <= load ? dp : (r_pend_valid ? r_pend_dp : r_shadow_dp);
      r_seg_dp <= (w_on && w_dp_bit) ^ w_pol[0];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_pending    <= '0;
      r_shadow     <= '0;
      r_pend_valid <= 1'b0;
      r_seg        <= SEG_MASK;
      r_dig        <= DIG_MASK;
      r_frame_done <= 1'b0;
    end else begin
      r_presc <= w_tc ? '0 : r_presc + 1'b1;
      if (w_tc) r_idx <= w_wrap ? '0 : r_idx + 1'b1;
      r_frame_done <= w_wrap;

      if (load) r_pending <= value;
      // Shadow only changes on the frame wrap; a load on that very cycle
      // bypasses pending so it is visible in the next digit-0 slot.
      if (w_wrap) begin
        r_shadow     <= load ? value : (r_pend_valid ? r_pending : r_shadow);
        r_pend_valid <= 1'b0;
      end else if (load) begin
        r_pend_valid <= 1'b1;
      end

      r_seg <= (w_on ? w_pat : 7'b0000000) ^ w_pol;
      r_dig <= (w_on ? w_onehot : '0) ^ DIG_MASK;
    end
  end

  assign seg        = r_seg;
  assign dig        = r_dig;
  assign frame_done = r_frame_done;

endmodule
